washer_water_arb: RTL
=====================

Name: washer_water_arb

Overview:
- Round-robin arbiter for the single shared water inlet valve in a multi-washer unit. Each washer controller raises a fill request.
- The block grants the valve to one washer at a time and holds the grant until that washer reports full, withdraws, or cancels.
- A watchdog times out a stuck fill and latches a per-washer error. A settle gap is enforced between successive holders.
- Sits between N washer controllers (their water_fill / water_full signals) and the physical valve driver.

Parameters:
- N_WASHERS, 4, number of requesters; legal range 2..16.
- T_FILL_MAX, 64, maximum cycles one grant may be held before timeout; must be >= 2.
- T_GAP, 2, valve-settle cycles with no grant between holders; must be >= 1.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- req  input  N_WASHERS  per-washer fill request (level).
- done  input  N_WASHERS  per-washer water_full indication.
- cancel  input  N_WASHERS  per-washer abort.
- clear_err  input  1  single-cycle pulse; clears all timeout_err bits.
- grant  output  N_WASHERS  one-hot (or zero) valve ownership.
- valve_open  output  1  drives the shared inlet valve; equals |grant.
- busy  output  1  high in GRANT or GAP.
- active_id  output  $clog2(N_WASHERS)  index of the current or last holder.
- timeout_err  output  N_WASHERS  sticky per-washer watchdog flag.

Behaviour:
- Reset (async, rstn low): state=IDLE; grant=0, valve_open=0, busy=0, active_id=0, timeout_err=0, rr pointer=0, timer=0. Reset mid-grant drops the valve immediately.
- All outputs are registered.
- Eligible requester: req[i]=1, timeout_err[i]=0 and cancel[i]=0.
- Round-robin selection: the first eligible index scanning ptr, ptr+1, … wrapping modulo N_WASHERS. On every grant, ptr <= winner+1 (wraps to 0).
- IDLE: if any requester is eligible at edge t, then at t+1: state=GRANT, grant=onehot(winner), active_id=winner, timer=0. Otherwise remain in IDLE.
- GRANT: timer increments each cycle. With h = active_id, evaluate in priority order:
  1. done[h], !req[h] or cancel[h]: normal release; state=GAP.
  2. timer==T_FILL_MAX-1: timeout; set timeout_err[h]; state=GAP.
  3. Otherwise hold.
- GRANT timing: grant drops on the edge after the release or timeout condition. Grant is high for at most T_FILL_MAX cycles. If done and timeout coincide, done wins and no error is set.
- GAP: grant=0 for exactly T_GAP cycles (gap counter). On the last GAP cycle, if an eligible requester exists, go directly to GRANT (no IDLE cycle). Otherwise go to IDLE.
- Back-to-back holders therefore see exactly T_GAP grant-low cycles between them.
- Requests raised during GRANT or GAP wait; there is no preemption.
- A cancel to a non-holder only masks that washer while cancel is high.
- clear_err: clears all timeout_err bits on the next edge. If clear_err coincides with a timeout set, the set wins for that bit.
- active_id holds its value in GAP and IDLE.
- The grant is never asserted to a requester whose timeout_err=1.
- Counter widths: timer is $clog2(T_FILL_MAX) bits; gap counter is $clog2(T_GAP+1) bits. Neither counter ever wraps.

Test Plan (N_WASHERS=4, T_FILL_MAX=8, T_GAP=2):
- Reset then req=4'b0010 at t0 -> grant=4'b0010 and valve_open=1 at t0+1; done[1] pulsed at t0+4 -> grant=0 at t0+5; busy=0 from t0+7.
- req=4'b1111 held, each holder pulses done 3 cycles after its grant -> grant order 0001,0010,0100,1000,0001, with exactly 2 zero-grant cycles between holders.
- req=4'b0100, done never asserted -> grant high 8 cycles, then timeout_err=4'b0100, grant=0. Keep req[2]=1 -> no further grant to 2 until a clear_err pulse; grant=4'b0100 again 1 cycle after clear (when in IDLE).
- Holder 3 with done[3] asserted on the same cycle timer==7 -> release with timeout_err[3]=0.
- cancel[0] while holding -> grant drops next edge. req=4'b0011 with cancel[1]=1 during arbitration -> washer 1 skipped; washer 0 granted.
- Assert rstn=0 mid-grant -> grant, valve_open and busy go to 0 asynchronously. After release, req=4'b1000 -> grant in 1 cycle and ptr starts from 0.

Source files
------------

// File: rtl/washer_water_arb.sv
// Round-robin owner of the shared water inlet valve: one washer fills at a time,
// a watchdog latches per-washer errors, and a settle gap separates successive holders.
module washer_water_arb #(
   parameter int N_WASHERS  = 4,
   parameter int T_FILL_MAX = 64,
   parameter int T_GAP      = 2
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [N_WASHERS-1:0]          req,
   input  logic [N_WASHERS-1:0]          done,
   input  logic [N_WASHERS-1:0]          cancel,
   input  logic                          clear_err,
   output logic [N_WASHERS-1:0]          grant,
   output logic                          valve_open,
   output logic                          busy,
   output logic [$clog2(N_WASHERS)-1:0]  active_id,
   output logic [N_WASHERS-1:0]          timeout_err
);

   localparam int IW = $clog2(N_WASHERS);
   localparam int TW = $clog2(T_FILL_MAX);
   localparam int GW = $clog2(T_GAP + 1);
   localparam logic [TW-1:0] TLAST = TW'(T_FILL_MAX - 1);
   localparam logic [GW-1:0] GLAST = GW'(T_GAP - 1);
   localparam logic [IW-1:0] ILAST = IW'(N_WASHERS - 1);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t                 state_q;
   logic [N_WASHERS-1:0]   grant_q;
   logic                   valve_q;
   logic                   busy_q;
   logic [IW-1:0]          active_id_q;
   logic [N_WASHERS-1:0]   timeout_err_q;
   logic [IW-1:0]          ptr_q;
   logic [TW-1:0]          timer_q;
   logic [GW-1:0]          gap_q;

   logic [N_WASHERS-1:0]   elig;
   logic                   win_vld;
   logic [IW-1:0]          win_id_d;
   logic [N_WASHERS-1:0]   win_oh_d;
   logic [IW-1:0]          ptr_d;
   logic [N_WASHERS-1:0]   hold_oh;
   logic [N_WASHERS-1:0]   err_d;
   logic                   rel;

   assign elig  = req & ~timeout_err_q & ~cancel;
   assign err_d = clear_err ? '0 : timeout_err_q;
   assign rel   = done[active_id_q] | ~req[active_id_q] | cancel[active_id_q];

   // First eligible washer scanning upward from the round-robin pointer.
   always_comb begin
      int idx;
      win_vld  = 1'b0;
      win_id_d = '0;
      for (int k = 0; k < N_WASHERS; k++) begin
         idx = (int'(ptr_q) + k) % N_WASHERS;
         if (!win_vld && elig[idx]) begin
            win_vld  = 1'b1;
            win_id_d = idx[IW-1:0];
         end
      end
      win_oh_d           = '0;
      win_oh_d[win_id_d] = 1'b1;
      hold_oh              = '0;
      hold_oh[active_id_q] = 1'b1;
      ptr_d = (win_id_d == ILAST) ? '0 : win_id_d + IW'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         valve_q       <= 1'b0;
         busy_q        <= 1'b0;
         active_id_q   <= '0;
         timeout_err_q <= '0;
         ptr_q         <= '0;
         timer_q       <= '0;
         gap_q         <= '0;
      end else begin
         timeout_err_q <= err_d;
         case (state_q)
            IDLE: begin
               if (win_vld) begin
                  state_q     <= GRANT;
                  grant_q     <= win_oh_d;
                  valve_q     <= 1'b1;
                  busy_q      <= 1'b1;
                  active_id_q <= win_id_d;
                  ptr_q       <= ptr_d;
                  timer_q     <= '0;
               end
            end
            GRANT: begin
               // A normal release outranks the watchdog, so done on the last cycle sets no error.
               if (rel || timer_q == TLAST) begin
                  state_q <= GAP;
                  grant_q <= '0;
                  valve_q <= 1'b0;
                  gap_q   <= '0;
                  if (!rel) timeout_err_q <= err_d | hold_oh;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            GAP: begin
               if (gap_q == GLAST) begin
                  if (win_vld) begin
                     state_q     <= GRANT;
                     grant_q     <= win_oh_d;
                     valve_q     <= 1'b1;
                     active_id_q <= win_id_d;
                     ptr_q       <= ptr_d;
                     timer_q     <= '0;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  gap_q <= gap_q + GW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant       = grant_q;
   assign valve_open  = valve_q;
   assign busy        = busy_q;
   assign active_id   = active_id_q;
   assign timeout_err = timeout_err_q;

endmodule
